// File: rtl/body_pkg.sv
// body_pkg: shared types, widths and initial state for the three-body update sequencer
package body_pkg;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int V_W = 8;
  localparam int D_W = 10;
  localparam logic [D_W-1:0] NEAR_D_DEF = 10'd20;
  localparam logic [D_W-1:0] FAR_D_DEF = 10'd150;
  localparam logic [3*X_W-1:0] INIT_X = {9'd100, 9'd210, 9'd150};
  localparam logic [3*Y_W-1:0] INIT_Y = {8'd10, 8'd150, 8'd75};
  typedef enum logic [2:0] {IDLE, PAIR, POS, VEL, COMMIT} state_t;
  typedef logic [1:0] body_idx_t;
endpackage

// File: rtl/body_update_sequencer_if.sv
// body_update_sequencer_if: frame control inputs and committed body state outputs
interface body_update_sequencer_if;
  import body_pkg::*;
  logic frame_tick;
  logic pause;
  logic reseed;
  logic [3*X_W-1:0] pos_x;
  logic [3*Y_W-1:0] pos_y;
  logic busy;
  logic done;
  logic overrun;
  logic [7:0] frame_count;
  modport master (output frame_tick, pause, reseed, input pos_x, pos_y, busy, done, overrun, frame_count);
  modport slave (input frame_tick, pause, reseed, output pos_x, pos_y, busy, done, overrun, frame_count);
endinterface

// File: rtl/pair_force_unit.sv
// pair_force_unit: Manhattan-distance banded force between two bodies, signed per axis
module pair_force_unit
  import body_pkg::*;
(
  input  logic [X_W-1:0] xi,
  input  logic [Y_W-1:0] yi,
  input  logic [X_W-1:0] xj,
  input  logic [Y_W-1:0] yj,
  input  logic [D_W-1:0] near_d,
  input  logic [D_W-1:0] far_d,
  output logic signed [2:0] fx,
  output logic signed [2:0] fy
);
  logic [D_W-1:0] dx, dy, adx, ady, d;
  logic [2:0] f;
  // 10-bit differences hold +/-511, so |dx|+|dy| never exceeds 766; zero difference counts as positive
  always_comb begin
    dx = D_W'(xj) - D_W'(xi);
    dy = D_W'(yj) - D_W'(yi);
    adx = dx[D_W-1] ? -dx : dx;
    ady = dy[D_W-1] ? -dy : dy;
    d = adx + ady;
    f = d < near_d ? 3'd2 : d < far_d ? 3'd1 : 3'd0;
    fx = dx[D_W-1] ? -f : f;
    fy = dy[D_W-1] ? -f : f;
  end
endmodule

// File: rtl/body_update_sequencer.sv
// body_update_sequencer: one shared force unit over AB/AC/BC, then per-body position and velocity update, committed atomically
module body_update_sequencer
  import body_pkg::*;
#(
  parameter logic [D_W-1:0] NEAR_D = NEAR_D_DEF,
  parameter logic [D_W-1:0] FAR_D = FAR_D_DEF
) (
  input logic clk,
  input logic rst_n,
  body_update_sequencer_if.slave bus
);
  state_t state, state_n;
  body_idx_t idx, idx_n, pi, pj;
  logic [X_W-1:0] px [3];
  logic [X_W-1:0] sx [3];
  logic [Y_W-1:0] py [3];
  logic [Y_W-1:0] sy [3];
  logic [V_W-1:0] vx [3];
  logic [V_W-1:0] vy [3];
  logic [V_W-1:0] ax [3];
  logic [V_W-1:0] ay [3];
  logic [V_W-1:0] fxe, fye;
  logic signed [2:0] fx, fy;
  logic [7:0] fc;
  logic done_q, ovr, start, last;

  assign start = state == IDLE && bus.frame_tick && !bus.pause;
  assign last = idx == 2'd2;
  assign pi = idx == 2'd2 ? 2'd1 : 2'd0;
  assign pj = idx == 2'd0 ? 2'd1 : 2'd2;
  assign fxe = {{(V_W-3){fx[2]}}, fx};
  assign fye = {{(V_W-3){fy[2]}}, fy};

  pair_force_unit u_pf (
    .xi(px[pi]),
    .yi(py[pi]),
    .xj(px[pj]),
    .yj(py[pj]),
    .near_d(NEAR_D),
    .far_d(FAR_D),
    .fx(fx),
    .fy(fy)
  );

  // sequencer state and pair/body index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 2'd0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end

  // each working phase walks idx 0..2 before handing over; reseed wins over everything
  always_comb begin
    state_n = state;
    idx_n = last ? 2'd0 : idx + 2'd1;
    unique case (state)
      IDLE: begin
        state_n = start ? PAIR : IDLE;
        idx_n = 2'd0;
      end
      PAIR: state_n = last ? POS : PAIR;
      POS: state_n = last ? VEL : POS;
      VEL: state_n = last ? COMMIT : VEL;
      COMMIT: begin
        state_n = IDLE;
        idx_n = 2'd0;
      end
      default: state_n = IDLE;
    endcase
    if (bus.reseed) begin
      state_n = IDLE;
      idx_n = 2'd0;
    end
  end

  // accumulators, shadow/committed positions, velocities and status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        px[k] <= INIT_X[k*X_W +: X_W];
        py[k] <= INIT_Y[k*Y_W +: Y_W];
        sx[k] <= INIT_X[k*X_W +: X_W];
        sy[k] <= INIT_Y[k*Y_W +: Y_W];
        vx[k] <= '0;
        vy[k] <= '0;
        ax[k] <= '0;
        ay[k] <= '0;
      end
      fc <= '0;
      done_q <= 1'b0;
      ovr <= 1'b0;
    end else if (bus.reseed) begin
      for (int k = 0; k < 3; k++) begin
        px[k] <= INIT_X[k*X_W +: X_W];
        py[k] <= INIT_Y[k*Y_W +: Y_W];
        sx[k] <= INIT_X[k*X_W +: X_W];
        sy[k] <= INIT_Y[k*Y_W +: Y_W];
        vx[k] <= '0;
        vy[k] <= '0;
        ax[k] <= '0;
        ay[k] <= '0;
      end
      fc <= '0;
      done_q <= 1'b0;
      ovr <= 1'b0;
    end else begin
      done_q <= state == COMMIT;
      if (bus.frame_tick && state != IDLE) ovr <= 1'b1;
      unique case (state)
        IDLE: if (start) begin
          for (int k = 0; k < 3; k++) begin
            ax[k] <= '0;
            ay[k] <= '0;
          end
        end
        PAIR: begin
          ax[pi] <= ax[pi] + fxe;
          ay[pi] <= ay[pi] + fye;
          ax[pj] <= ax[pj] - fxe;
          ay[pj] <= ay[pj] - fye;
        end
        POS: begin
          sx[idx] <= px[idx] + {vx[idx][V_W-1], vx[idx]};
          sy[idx] <= py[idx] + vy[idx];
        end
        VEL: begin
          vx[idx] <= vx[idx] + ax[idx];
          vy[idx] <= vy[idx] + ay[idx];
        end
        COMMIT: begin
          for (int k = 0; k < 3; k++) begin
            px[k] <= sx[k];
            py[k] <= sy[k];
          end
          fc <= fc + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pos_x = {px[2], px[1], px[0]};
  assign bus.pos_y = {py[2], py[1], py[0]};
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.overrun = ovr;
  assign bus.frame_count = fc;
endmodule

// File: tb/tb_body_update_sequencer.sv
// tb_body_update_sequencer: frame-level reference model, per-cycle compare, directed and random stimulus
module tb_body_update_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  body_update_sequencer_if bus ();

  body_update_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run_chk = 0;

  int m_px[3], m_py[3], m_vx[3], m_vy[3], n_px[3], n_py[3];
  int m_cnt, m_fc;
  bit m_done, m_ovr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  function automatic int wrap(int v, int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic int sgn8(int v);
    return wrap(v + 128, 256) - 128;
  endfunction

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic void m_reset();
    m_px = '{150, 210, 100};
    m_py = '{75, 150, 10};
    n_px = m_px;
    n_py = m_py;
    m_vx = '{0, 0, 0};
    m_vy = '{0, 0, 0};
    m_cnt = 0;
    m_fc = 0;
    m_done = 0;
    m_ovr = 0;
  endfunction

  function automatic void m_frame();
    int acx[3] = '{0, 0, 0};
    int acy[3] = '{0, 0, 0};
    int pa[3] = '{0, 0, 1};
    int pb[3] = '{1, 2, 2};
    for (int p = 0; p < 3; p++) begin
      int dx, dy, d, f;
      dx = m_px[pb[p]] - m_px[pa[p]];
      dy = m_py[pb[p]] - m_py[pa[p]];
      d = iabs(dx) + iabs(dy);
      f = d < 20 ? 2 : d < 150 ? 1 : 0;
      acx[pa[p]] += dx < 0 ? -f : f;
      acx[pb[p]] -= dx < 0 ? -f : f;
      acy[pa[p]] += dy < 0 ? -f : f;
      acy[pb[p]] -= dy < 0 ? -f : f;
    end
    for (int b = 0; b < 3; b++) begin
      n_px[b] = wrap(m_px[b] + m_vx[b], 512);
      n_py[b] = wrap(m_py[b] + m_vy[b], 256);
      m_vx[b] = sgn8(m_vx[b] + acx[b]);
      m_vy[b] = sgn8(m_vy[b] + acy[b]);
    end
    m_cnt = 10;
  endfunction

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.reseed) m_reset();
    else begin
      m_done = 0;
      if (m_cnt > 0) begin
        if (bus.frame_tick) m_ovr = 1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_px = n_px;
          m_py = n_py;
          m_fc = (m_fc + 1) % 256;
          m_done = 1;
        end
      end else if (bus.frame_tick && !bus.pause) m_frame();
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("pos_x", 32'(bus.pos_x), 32'(m_px[2] * 262144 + m_px[1] * 512 + m_px[0]));
      chk("pos_y", 32'(bus.pos_y), 32'(m_py[2] * 65536 + m_py[1] * 256 + m_py[0]));
      chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
      chk("frame_count", 32'(bus.frame_count), 32'(m_fc));
    end
  end

  task automatic tick(input logic p);
    bus.frame_tick = 1'b1;
    bus.pause = p;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_first();
    chk("first_pos_x", 32'(bus.pos_x), 32'({9'd100, 9'd210, 9'd150}));
    chk("first_pos_y", 32'(bus.pos_y), 32'({8'd10, 8'd150, 8'd75}));
    chk("first_fc", 32'(bus.frame_count), 32'd1);
    chk("model_vA", 32'(m_vx[0] * 1000 + m_vy[0]), 32'd0);
    chk("model_vB", 32'(m_vx[1] * 1000 + m_vy[1]), 32'(-1001));
    chk("model_vC", 32'(m_vx[2] * 1000 + m_vy[2]), 32'd1001);
  endtask

  initial begin
    int n;
    bus.frame_tick = 1'b0;
    bus.pause = 1'b0;
    bus.reseed = 1'b0;
    @(negedge clk);
    run_chk = 1;
    @(negedge clk);
    chk("rst_pos_x", 32'(bus.pos_x), 32'({9'd100, 9'd210, 9'd150}));
    chk("rst_pos_y", 32'(bus.pos_y), 32'({8'd10, 8'd150, 8'd75}));
    chk("rst_status", 32'({bus.busy, bus.done, bus.overrun, bus.frame_count}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    tick(1'b0);
    wait_done();
    chk_first();
    tick(1'b0);
    wait_done();
    chk("second_pos_x", 32'(bus.pos_x), 32'({9'd101, 9'd209, 9'd150}));
    chk("second_pos_y", 32'(bus.pos_y), 32'({8'd11, 8'd149, 8'd75}));
    chk("second_fc", 32'(bus.frame_count), 32'd2);
    tick(1'b1);
    repeat (14) @(negedge clk);
    chk("pause_fc", 32'(bus.frame_count), 32'd2);
    chk("pause_busy", 32'(bus.busy), 32'd0);
    tick(1'b0);
    n = 0;
    while (bus.busy && n < 30) begin
      n++;
      bus.frame_tick = n == 4;
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    chk("busy_len", 32'(n), 32'd10);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_done", 32'(bus.done), 32'd1);
    tick(1'b0);
    wait_done();
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    chk("ovr_fc", 32'(bus.frame_count), 32'd4);
    tick(1'b0);
    repeat (3) @(negedge clk);
    bus.reseed = 1'b1;
    @(negedge clk);
    bus.reseed = 1'b0;
    chk("reseed_status", 32'({bus.busy, bus.done, bus.overrun, bus.frame_count}), 32'd0);
    chk("reseed_pos_x", 32'(bus.pos_x), 32'({9'd100, 9'd210, 9'd150}));
    repeat (12) begin
      @(negedge clk);
      chk("reseed_no_done", 32'(bus.done), 32'd0);
    end
    tick(1'b0);
    wait_done();
    chk_first();
    for (int c = 0; c < 5000; c++) begin
      bus.frame_tick = $urandom_range(0, 5) == 0;
      bus.pause = $urandom_range(0, 3) == 0;
      bus.reseed = $urandom_range(0, 399) == 0;
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    bus.pause = 1'b0;
    bus.reseed = 1'b0;
    repeat (12) @(negedge clk);
    run_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
